mobo_ram_burst_bridge: RTL and testbench
========================================

// Module: mobo_ram_burst_bridge
// PURPOSE
//  Clocked, parametrised motherboard-to-RAM bridge. Replaces the combinational single-word path.
//  Accepts a CPU-side read or write of 1..2^LEN_W beats at incrementing addresses.
//  Drives the RAM through the ram_ctrl/ram_stat 4-phase pin handshake and adds a watchdog timeout.
//  Sits between the mobo address-translation stage and the RAM model.
// PARAMETERS
//  WORD_WIDTH   `WORD_WIDTH  data/address/ctrl/stat word width
//  LEN_W        4            burst-length field width; beats = req_len+1 (max 16)
//  ADDR_STEP    1            address increment per beat
//  TIMEOUT_CYC  256          max cycles waiting on one ack edge; 0 disables watchdog
// PORTS
//  clk          in   1           system clock, rising edge
//  rst_n        in   1           asynchronous active-low reset
//  req          in   1           start request; sampled in IDLE only
//  req_we       in   1           1=write burst, 0=read burst
//  req_addr     in   WORD_WIDTH  translated start address
//  req_len      in   LEN_W       beats minus one
//  wdata        in   WORD_WIDTH  write data for current beat
//  wdata_pop    out  1           1-cycle pulse: wdata consumed, present next beat
//  rdata        out  WORD_WIDTH  read data, valid with rdata_valid
//  rdata_valid  out  1           1-cycle pulse per read beat
//  busy         out  1           high from accept until done
//  done         out  1           1-cycle pulse at burst end (normal or error)
//  err          out  1           valid with done: 1=timeout abort
//  ram_stat     in   WORD_WIDTH  RAM status; bit `RAM_ACK used
//  ram_ctrl     out  WORD_WIDTH  RAM control; bits `RAM_READ_PIN/`RAM_WRITE_PIN, other bits 0
//  ram_addr     out  WORD_WIDTH  RAM address
//  ram_wdata    out  WORD_WIDTH  RAM write data
//  ram_rdata    in   WORD_WIDTH  RAM read data
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. All outputs are registered.
//  IDLE: req=1 -> latch we, addr, len; busy=1; go ISSUE. Without req, stay in IDLE.
//  ISSUE: wait for ram_stat[ACK]=0. Then set the RD or WR pin, drive ram_addr.
//    For writes, also drive ram_wdata=wdata. Go WAIT_HI.
//  WAIT_HI: on ACK=1: clear ram_ctrl. For a read, capture rdata<=ram_rdata and pulse rdata_valid.
//    For a write, pulse wdata_pop. Go WAIT_LO.
//  WAIT_LO: on ACK=0: if beat_cnt==len go DONE. Otherwise beat_cnt++, addr+=ADDR_STEP, go ISSUE.
//  DONE: pulse done with err=0, busy=0, return to IDLE. A new req is accepted the following cycle.
//  Latency: a single beat with a zero-wait RAM completes in ISSUE+WAIT_HI+WAIT_LO+DONE = 4 clocks min.
//  Address wraps modulo 2^WORD_WIDTH, with no error.
//  Pins: RD and WR are never high together. A pin is never raised while ACK=1.
//  Watchdog: the counter resets on every state change and counts in ISSUE, WAIT_HI and WAIT_LO.
//    On reaching TIMEOUT_CYC: ram_ctrl=0, then go DONE with err=1.
//    Remaining beats are dropped; no further wdata_pop or rdata_valid.
//  req while busy: ignored; no queueing.
//  req_* inputs may change after accept without effect.
//  Async reset mid-burst: ram_ctrl drops to 0 immediately; no done pulse is issued.
// STRUCTURE
//  Shared defines/package: `WORD_WIDTH, `RAM_ACK, `RAM_READ_PIN, `RAM_WRITE_PIN, state encoding.
//  State encoding constants: BRG_IDLE/ISSUE/WAIT_HI/WAIT_LO/DONE.
//  One sub-module: ram_watchdog (clk, rst_n, clear, enable -> expired), parametrised by TIMEOUT_CYC.
// TESTING
//  1 write, len=0, addr=0x10, wdata=0xAB, RAM acks after 2 cycles
//    -> ram_ctrl WR high with ram_addr=0x10 and ram_wdata=0xAB; one wdata_pop; done=1, err=0.
//  2 read, len=3, addr=0x20, RAM returns addr^0x55
//    -> 4 rdata_valid pulses with 0x75,0x74,0x77,0x76 in order; ram_addr 0x20..0x23; done once.
//  3 ACK held high at request -> no pin raised until ACK falls. Then the normal handshake runs.
//  4 TIMEOUT_CYC=8, RAM never acks
//    -> ram_ctrl=0 and done=1, err=1 exactly 8 cycles after entering WAIT_HI.
//  5 write len=1 at addr=all-ones -> second beat at addr 0; req pulsed while busy is ignored.
//  6 rst_n low during WAIT_HI of a read
//    -> ram_ctrl=0 at once, no done pulse. A fresh req after release completes normally.

Source files
------------

// File: rtl/mobo_ram_burst_bridge_pkg.sv
// Shared widths, RAM pin positions and bridge state encoding for the mobo-to-RAM burst bridge.
package mobo_ram_burst_bridge_pkg;

    localparam int BRG_WORD_WIDTH = 8;
    localparam int RAM_ACK        = 0;
    localparam int RAM_READ_PIN   = 0;
    localparam int RAM_WRITE_PIN  = 1;

    typedef enum logic [2:0] {
        BRG_IDLE    = 3'd0,
        BRG_ISSUE   = 3'd1,
        BRG_WAIT_HI = 3'd2,
        BRG_WAIT_LO = 3'd3,
        BRG_DONE    = 3'd4
    } brg_state_e;

endpackage

// File: rtl/ram_watchdog.sv
// Per-edge handshake watchdog: down-counter reloaded on clear, expires at terminal count.
module ram_watchdog #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            logic unused_in;
            assign unused_in = ^{clk, rst_n, clear_i, enable_i};
            assign expired_o = 1'b0;
        end else begin : g_on
            localparam int LOAD = TIMEOUT_CYC - 1;
            localparam int CW   = (LOAD > 0) ? $clog2(LOAD + 1) : 1;

            logic [CW-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear_i) begin
                    cnt_d = CW'(LOAD);
                end else if (enable_i && (cnt_q != '0)) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // Loaded with TIMEOUT_CYC-1 so the abort lands exactly TIMEOUT_CYC edges after entry.
            assign expired_o = enable_i && (cnt_q == '0);
        end
    endgenerate

endmodule

// File: rtl/mobo_ram_burst_bridge.sv
// Clocked CPU-to-RAM burst bridge: 4-phase ctrl/stat pin handshake per beat with watchdog abort.
// state   | meaning
// IDLE    | waiting for req
// ISSUE   | waiting for ACK low, then raise RD/WR pin
// WAIT_HI | pin high, waiting for ACK high
// WAIT_LO | pin dropped, waiting for ACK low
// DONE    | one-cycle done/err pulse
module mobo_ram_burst_bridge
    import mobo_ram_burst_bridge_pkg::*;
#(
    parameter int WORD_WIDTH  = BRG_WORD_WIDTH,
    parameter int LEN_W       = 4,
    parameter int ADDR_STEP   = 1,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic                  req_we_i,
    input  logic [WORD_WIDTH-1:0] req_addr_i,
    input  logic [LEN_W-1:0]      req_len_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    output logic                  wdata_pop_o,
    output logic [WORD_WIDTH-1:0] rdata_o,
    output logic                  rdata_valid_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    input  logic [WORD_WIDTH-1:0] ram_stat_i,
    output logic [WORD_WIDTH-1:0] ram_ctrl_o,
    output logic [WORD_WIDTH-1:0] ram_addr_o,
    output logic [WORD_WIDTH-1:0] ram_wdata_o,
    input  logic [WORD_WIDTH-1:0] ram_rdata_i
);

    brg_state_e            state_q, state_d;
    logic                  we_q, we_d;
    logic [WORD_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      beat_q, beat_d;
    logic [WORD_WIDTH-1:0] ram_ctrl_q, ram_ctrl_d;
    logic [WORD_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [WORD_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic                  wdata_pop_q, wdata_pop_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  ack, wd_clear, wd_enable, wd_expired;
    logic [WORD_WIDTH-1:0] pin_word;
    logic                  stat_unused;

    assign ack         = ram_stat_i[RAM_ACK];
    assign stat_unused = ^ram_stat_i;
    assign wd_enable   = (state_q == BRG_ISSUE) || (state_q == BRG_WAIT_HI) || (state_q == BRG_WAIT_LO);
    assign wd_clear    = (state_d != state_q);

    ram_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    always_comb begin
        pin_word = '0;
        if (we_q) begin
            pin_word[RAM_WRITE_PIN] = 1'b1;
        end else begin
            pin_word[RAM_READ_PIN] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        addr_d        = addr_q;
        len_d         = len_q;
        beat_d        = beat_q;
        ram_ctrl_d    = ram_ctrl_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        wdata_pop_d   = 1'b0;
        err_d         = 1'b0;
        unique case (state_q)
            BRG_IDLE: begin
                if (req_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    len_d   = req_len_i;
                    beat_d  = '0;
                    state_d = BRG_ISSUE;
                end
            end
            BRG_ISSUE: begin
                if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = BRG_DONE;
                end else if (!ack) begin
                    ram_ctrl_d = pin_word;
                    ram_addr_d = addr_q;
                    if (we_q) begin
                        ram_wdata_d = wdata_i;
                    end
                    state_d = BRG_WAIT_HI;
                end
            end
            BRG_WAIT_HI: begin
                if (wd_expired) begin
                    ram_ctrl_d = '0;
                    err_d      = 1'b1;
                    state_d    = BRG_DONE;
                end else if (ack) begin
                    ram_ctrl_d = '0;
                    if (we_q) begin
                        wdata_pop_d = 1'b1;
                    end else begin
                        rdata_d       = ram_rdata_i;
                        rdata_valid_d = 1'b1;
                    end
                    state_d = BRG_WAIT_LO;
                end
            end
            BRG_WAIT_LO: begin
                if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = BRG_DONE;
                end else if (!ack) begin
                    if (beat_q == len_q) begin
                        state_d = BRG_DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        addr_d  = addr_q + WORD_WIDTH'(ADDR_STEP);
                        state_d = BRG_ISSUE;
                    end
                end
            end
            BRG_DONE: state_d = BRG_IDLE;
            default:  state_d = BRG_IDLE;
        endcase
        busy_d = (state_d != BRG_IDLE) && (state_d != BRG_DONE);
        done_d = (state_d == BRG_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BRG_IDLE;
            we_q          <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            beat_q        <= '0;
            ram_ctrl_q    <= '0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            wdata_pop_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            beat_q        <= beat_d;
            ram_ctrl_q    <= ram_ctrl_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            wdata_pop_q   <= wdata_pop_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign ram_ctrl_o    = ram_ctrl_q;
    assign ram_addr_o    = ram_addr_q;
    assign ram_wdata_o   = ram_wdata_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign wdata_pop_o   = wdata_pop_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_mobo_ram_burst_bridge.sv
// Bench for mobo_ram_burst_bridge: behavioural RAM responder, bus monitor and per-scenario tasks.
module tb_mobo_ram_burst_bridge;
    import mobo_ram_burst_bridge_pkg::*;

    localparam int W  = BRG_WORD_WIDTH;
    localparam int LW = 4;
    localparam int TO = 8;
    localparam logic [W-1:0] PIN_MASK = (W'(1) << RAM_READ_PIN) | (W'(1) << RAM_WRITE_PIN);

    typedef struct { logic we; logic [W-1:0] addr; logic [W-1:0] wdata; int cyc; } beat_t;
    typedef struct { logic err; logic [W-1:0] ctrl; int cyc; } done_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_i, req_we_i;
    logic [W-1:0]  req_addr_i, wdata_i, rdata_o, ram_stat_i, ram_ctrl_o, ram_addr_o, ram_wdata_o, ram_rdata_i;
    logic [LW-1:0] req_len_i;
    logic          wdata_pop_o, rdata_valid_o, busy_o, done_o, err_o;

    always #5 clk = ~clk;

    mobo_ram_burst_bridge #(.WORD_WIDTH(W), .LEN_W(LW), .ADDR_STEP(1), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_len_i(req_len_i), .wdata_i(wdata_i), .wdata_pop_o(wdata_pop_o), .rdata_o(rdata_o),
        .rdata_valid_o(rdata_valid_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .ram_stat_i(ram_stat_i), .ram_ctrl_o(ram_ctrl_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    int vectors = 0, miscompares = 0, cyc = 0;
    beat_t beats[$];
    logic [W-1:0] rd_q[$];
    done_t done_q[$];
    logic [W-1:0] wd_list[$];
    int wd_idx = 0, pops = 0, both_pins = 0, stray_bits = 0, raise_under_ack = 0;
    int ram_delay = 1;
    bit ram_dead = 1'b0, ram_hold_ack = 1'b0;

    // RAM responder: acks a raised pin after ram_delay cycles, returns addr^0x55, drops ack after pin falls.
    initial begin : ram_model
        int wait_cnt;
        wait_cnt = 0; ram_stat_i = '0; ram_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            if (ram_hold_ack) begin
                ram_stat_i[RAM_ACK] = 1'b1;
            end else if (!ram_stat_i[RAM_ACK]) begin
                if (((ram_ctrl_o & PIN_MASK) != '0) && !ram_dead) begin
                    if (wait_cnt >= ram_delay) begin
                        ram_stat_i[RAM_ACK] = 1'b1;
                        ram_rdata_i = ram_addr_o ^ W'('h55);
                        wait_cnt = 0;
                    end else wait_cnt++;
                end else wait_cnt = 0;
            end else if (ram_ctrl_o == '0) begin
                if (wait_cnt >= ram_delay) begin
                    ram_stat_i[RAM_ACK] = 1'b0;
                    wait_cnt = 0;
                end else wait_cnt++;
            end
        end
    end

    initial begin : monitor
        logic [W-1:0] prev_ctrl;
        logic prev_ack;
        beat_t b;
        done_t d;
        prev_ctrl = '0; prev_ack = 1'b0; wdata_i = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (ram_ctrl_o[RAM_READ_PIN] && ram_ctrl_o[RAM_WRITE_PIN]) both_pins++;
            if ((ram_ctrl_o & ~PIN_MASK) != '0) stray_bits++;
            if (ram_ctrl_o != '0 && prev_ctrl == '0) begin
                if (prev_ack) raise_under_ack++;
                b.we = ram_ctrl_o[RAM_WRITE_PIN]; b.addr = ram_addr_o; b.wdata = ram_wdata_o; b.cyc = cyc;
                beats.push_back(b);
            end
            if (rdata_valid_o) rd_q.push_back(rdata_o);
            if (wdata_pop_o) begin pops++; wd_idx++; end
            if (done_o) begin d.err = err_o; d.ctrl = ram_ctrl_o; d.cyc = cyc; done_q.push_back(d); end
            wdata_i = (wd_idx < int'(wd_list.size())) ? wd_list[wd_idx] : '0;
            prev_ctrl = ram_ctrl_o; prev_ack = ram_stat_i[RAM_ACK];
        end
    end

    task automatic clear_logs();
        beats.delete(); rd_q.delete(); done_q.delete(); pops = 0; wd_idx = 0;
    endtask

    task automatic start_req(input logic we, input logic [W-1:0] addr, input logic [LW-1:0] len);
        @(negedge clk);
        req_i = 1'b1; req_we_i = we; req_addr_i = addr; req_len_i = len;
        @(negedge clk);
        req_i = 1'b0; req_we_i = 1'($urandom); req_addr_i = W'($urandom); req_len_i = LW'($urandom);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_q.size() != 0) begin ok = 1'b1; break; end
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ram_ctrl_o, ram_addr_o, ram_wdata_o, rdata_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_words: got ctrl=%h addr=%h wdata=%h rdata=%h want all 0",
                     ram_ctrl_o, ram_addr_o, ram_wdata_o, rdata_o);
        end
        vectors++;
        if ({wdata_pop_o, rdata_valid_o, busy_o, done_o, err_o} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got pop,rv,busy,done,err=%b want 00000",
                     {wdata_pop_o, rdata_valid_o, busy_o, done_o, err_o});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        bit ok;
        clear_logs(); ram_delay = 2; wd_list = {W'('hAB)};
        start_req(1'b1, W'('h10), '0);
        wait_done(100, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL wr1_done: got no done want done within 100 cycles"); end
        vectors++;
        if (beats.size() != 1) begin
            miscompares++; $display("FAIL wr1_beats: got %0d beats want 1", beats.size());
        end else begin
            vectors++;
            if (beats[0].we !== 1'b1 || beats[0].addr !== W'('h10) || beats[0].wdata !== W'('hAB)) begin
                miscompares++;
                $display("FAIL wr1_pins: got we=%b addr=%h wdata=%h want we=1 addr=10 wdata=ab",
                         beats[0].we, beats[0].addr, beats[0].wdata);
            end
        end
        vectors++;
        if (pops != 1) begin miscompares++; $display("FAIL wr1_pops: got %0d want 1", pops); end
        vectors++;
        if (done_q.size() != 1 || done_q[0].err !== 1'b0) begin
            miscompares++; $display("FAIL wr1_done_err: got %0d dones want exactly 1 with err=0", done_q.size());
        end
    endtask

    task automatic test_read_burst();
        bit ok;
        logic [W-1:0] exp_rd [4];
        exp_rd = '{W'('h75), W'('h74), W'('h77), W'('h76)};
        clear_logs(); ram_delay = 1; wd_list.delete();
        start_req(1'b0, W'('h20), LW'(3));
        wait_done(200, ok);
        vectors++;
        if (!ok || done_q.size() != 1 || done_q[0].err !== 1'b0) begin
            miscompares++; $display("FAIL rd4_done: got ok=%0d dones=%0d want 1 clean done", ok, done_q.size());
        end
        vectors++;
        if (rd_q.size() != 4 || beats.size() != 4) begin
            miscompares++; $display("FAIL rd4_count: got rdata=%0d beats=%0d want 4/4", rd_q.size(), beats.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (rd_q[i] !== exp_rd[i] || beats[i].addr !== W'('h20 + i) || beats[i].we !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rd4_beat%0d: got rdata=%h addr=%h we=%b want rdata=%h addr=%h we=0",
                             i, rd_q[i], beats[i].addr, beats[i].we, exp_rd[i], W'('h20 + i));
                end
            end
        end
    endtask

    task automatic test_ack_held();
        bit ok;
        clear_logs(); ram_delay = 0; ram_hold_ack = 1'b1;
        repeat (2) @(negedge clk);
        wd_list = {W'('h5A)};
        start_req(1'b1, W'('h40), '0);
        repeat (3) @(negedge clk);
        vectors++;
        if (beats.size() != 0 || busy_o !== 1'b1) begin
            miscompares++; $display("FAIL ackheld_wait: got beats=%0d busy=%b want 0 beats busy=1", beats.size(), busy_o);
        end
        ram_hold_ack = 1'b0;
        wait_done(100, ok);
        vectors++;
        if (!ok || beats.size() != 1 || done_q.size() != 1 || done_q[0].err !== 1'b0) begin
            miscompares++; $display("FAIL ackheld_done: got ok=%0d beats=%0d dones=%0d want 1 clean beat", ok, beats.size(), done_q.size());
        end else begin
            vectors++;
            if (beats[0].addr !== W'('h40) || beats[0].wdata !== W'('h5A)) begin
                miscompares++; $display("FAIL ackheld_beat: got addr=%h wdata=%h want 40/5a", beats[0].addr, beats[0].wdata);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        clear_logs(); ram_dead = 1'b1;
        start_req(1'b0, W'('h30), LW'(2));
        wait_done(100, ok);
        repeat (10) @(negedge clk);
        vectors++;
        if (!ok || done_q.size() != 1 || done_q[0].err !== 1'b1 || done_q[0].ctrl !== '0) begin
            miscompares++; $display("FAIL to_done: got ok=%0d dones=%0d want one done err=1 ctrl=0", ok, done_q.size());
        end
        vectors++;
        if (beats.size() != 1 || rd_q.size() != 0 || pops != 0) begin
            miscompares++; $display("FAIL to_dropped: got beats=%0d rdata=%0d pops=%0d want 1/0/0", beats.size(), rd_q.size(), pops);
        end else if (done_q.size() == 1) begin
            vectors++;
            if (done_q[0].cyc - beats[0].cyc != TO) begin
                miscompares++; $display("FAIL to_latency: got %0d cycles want %0d", done_q[0].cyc - beats[0].cyc, TO);
            end
        end
        ram_dead = 1'b0;
    endtask

    task automatic test_wrap_and_busy_req();
        bit ok;
        logic [W-1:0] w0, w1;
        w0 = W'($urandom); w1 = W'($urandom);
        clear_logs(); ram_delay = 2; wd_list = {w0, w1};
        start_req(1'b1, '1, LW'(1));
        @(negedge clk);
        req_i = 1'b1; req_we_i = 1'b0; req_addr_i = W'('h99); req_len_i = LW'(5);
        @(negedge clk);
        req_i = 1'b0;
        wait_done(200, ok);
        repeat (10) @(negedge clk);
        vectors++;
        if (!ok || done_q.size() != 1 || beats.size() != 2 || pops != 2) begin
            miscompares++; $display("FAIL wrap_count: got ok=%0d dones=%0d beats=%0d pops=%0d want 1/2/2", ok, done_q.size(), beats.size(), pops);
        end else begin
            vectors++;
            if (beats[0].addr !== '1 || beats[1].addr !== '0 || beats[0].we !== 1'b1 || beats[1].we !== 1'b1) begin
                miscompares++; $display("FAIL wrap_addr: got %h,%h want ff,00 writes", beats[0].addr, beats[1].addr);
            end
            vectors++;
            if (beats[0].wdata !== w0 || beats[1].wdata !== w1) begin
                miscompares++; $display("FAIL wrap_wdata: got %h,%h want %h,%h", beats[0].wdata, beats[1].wdata, w0, w1);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        bit ok, seen;
        clear_logs(); ram_delay = 3; wd_list.delete();
        start_req(1'b0, W'('h50), LW'(1));
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ram_ctrl_o[RAM_READ_PIN]) begin seen = 1'b1; break; end
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL rst_mid_pin: got no RD pin want RD within 20 cycles"); end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (ram_ctrl_o !== '0 || busy_o !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_async: got ctrl=%h busy=%b want 0/0", ram_ctrl_o, busy_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (done_q.size() != 0) begin miscompares++; $display("FAIL rst_mid_nodone: got %0d dones want 0", done_q.size()); end
        clear_logs(); ram_delay = 1;
        start_req(1'b0, W'('h60), '0);
        wait_done(100, ok);
        vectors++;
        if (!ok || rd_q.size() != 1 || done_q.size() != 1 || done_q[0].err !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_fresh: got ok=%0d rdata=%0d dones=%0d want clean 1-beat read", ok, rd_q.size(), done_q.size());
        end else begin
            vectors++;
            if (rd_q[0] !== W'('h35)) begin miscompares++; $display("FAIL rst_mid_data: got %h want 35", rd_q[0]); end
        end
    endtask

    task automatic test_back_to_back();
        int nd, len;
        len = $urandom_range(0, 3);
        clear_logs(); ram_delay = 0; wd_list.delete();
        @(negedge clk);
        req_i = 1'b1; req_we_i = 1'b0; req_addr_i = W'($urandom); req_len_i = LW'(len);
        nd = 0;
        for (int i = 0; i < 200 && nd < 2; i++) begin
            @(negedge clk);
            if (done_o) nd++;
        end
        req_i = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (nd != 2 || done_q.size() != 2 || beats.size() != 2 * (len + 1)) begin
            miscompares++; $display("FAIL b2b_count: got dones=%0d beats=%0d want 2/%0d", done_q.size(), beats.size(), 2 * (len + 1));
        end else begin
            vectors++;
            if (beats[len + 1].cyc - done_q[0].cyc != 3) begin
                miscompares++; $display("FAIL b2b_gap: got %0d cycles done-to-pin want 3", beats[len + 1].cyc - done_q[0].cyc);
            end
        end
    endtask

    task automatic test_random_bursts();
        for (int n = 0; n < 12; n++) begin
            bit ok;
            logic we;
            logic [W-1:0] a, ea;
            int len;
            we = 1'($urandom); a = W'($urandom); len = $urandom_range(0, 15);
            ram_delay = $urandom_range(0, 3);
            clear_logs(); wd_list.delete();
            for (int k = 0; k <= len; k++) wd_list.push_back(W'($urandom));
            start_req(we, a, LW'(len));
            wait_done(600, ok);
            vectors++;
            if (!ok || done_q.size() != 1 || done_q[0].err !== 1'b0) begin
                miscompares++; $display("FAIL rnd%0d_done: got ok=%0d dones=%0d want one clean done", n, ok, done_q.size());
            end
            vectors++;
            if (beats.size() != len + 1 || pops != (we ? len + 1 : 0) || rd_q.size() != (we ? 0 : len + 1)) begin
                miscompares++;
                $display("FAIL rnd%0d_count: got beats=%0d pops=%0d rdata=%0d want %0d beats we=%b",
                         n, beats.size(), pops, rd_q.size(), len + 1, we);
            end else begin
                for (int k = 0; k <= len; k++) begin
                    ea = a + W'(k);
                    vectors++;
                    if (beats[k].addr !== ea || beats[k].we !== we ||
                        (we && beats[k].wdata !== wd_list[k]) || (!we && rd_q[k] !== (ea ^ W'('h55)))) begin
                        miscompares++;
                        $display("FAIL rnd%0d_beat%0d: got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h rdata=%h",
                                 n, k, beats[k].addr, beats[k].we, beats[k].wdata, ea, we, wd_list[k], ea ^ W'('h55));
                    end
                end
            end
        end
    endtask

    task automatic test_pin_rules();
        vectors++;
        if (both_pins != 0 || stray_bits != 0 || raise_under_ack != 0) begin
            miscompares++;
            $display("FAIL pin_rules: got both=%0d stray=%0d raised_under_ack=%0d want 0/0/0", both_pins, stray_bits, raise_under_ack);
        end
    endtask

    initial begin
        req_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_len_i = '0;
        test_reset();
        test_single_write();
        test_read_burst();
        test_ack_held();
        test_timeout();
        test_wrap_and_busy_req();
        test_reset_mid_read();
        test_back_to_back();
        test_random_bursts();
        test_pin_rules();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion want finish before 500000 time units");
        $fatal(1, "bench time limit expired");
    end

endmodule
